// File: rtl/alu_slt_checker_if.sv
// Vector stream from the ALU response tap into the SLT checker.
interface alu_slt_checker_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_rd;
    logic            in_unsigned;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_unsigned,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_unsigned,
        output in_ready
    );
endinterface

// File: rtl/alu_slt_checker.sv
// Set-less-than response checker: accepts a fixed-length run of vectors,
// scores each one a cycle after acceptance and keeps the first mismatch.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no run since reset; waiting for start
// ST_RUN   | accepting vectors until num_vec have been taken
// ST_DRAIN | last accepted vector is being scored
// ST_DONE  | counts final, done held until the next start
module alu_slt_checker #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    alu_slt_checker_if.slave in_if,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [XLEN-1:0]  fail_rs1,
    output logic [XLEN-1:0]  fail_rs2,
    output logic [XLEN-1:0]  fail_rd
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic             in_ready_q;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] accepted;

    logic             stage_valid;
    logic [XLEN-1:0]  stage_rs1;
    logic [XLEN-1:0]  stage_rs2;
    logic [XLEN-1:0]  stage_rd;
    logic             stage_uns;

    logic             stage_lt;
    logic [XLEN-1:0]  stage_exp;
    logic             stage_match;
    logic             handshake;

    // in_ready comes straight from a flop so it never follows in_valid.
    assign in_if.in_ready = in_ready_q;
    assign handshake      = in_if.in_valid & in_ready_q;

    // Expected SLT/SLTU result for the vector held in the stage register.
    always_comb begin
        stage_lt = 1'b0;
        if (stage_uns) begin
            stage_lt = (stage_rs1 < stage_rs2);
        end else begin
            stage_lt = ($signed(stage_rs1) < $signed(stage_rs2));
        end
        stage_exp   = {{(XLEN-1){1'b0}}, stage_lt};
        stage_match = (stage_rd == stage_exp);
    end

    // Run sequencing, vector capture and scoring with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            num_lat     <= '0;
            accepted    <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            fail_rs1    <= '0;
            fail_rs2    <= '0;
            fail_rd     <= '0;
            stage_valid <= 1'b0;
            stage_rs1   <= '0;
            stage_rs2   <= '0;
            stage_rd    <= '0;
            stage_uns   <= 1'b0;
        end else begin
            stage_valid <= 1'b0;

            // Score whatever was accepted on the previous cycle.
            if (stage_valid) begin
                if (stage_match) begin
                    if (pass_cnt != {CNT_W{1'b1}}) begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end
                end else begin
                    if (fail_cnt != {CNT_W{1'b1}}) begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                    end
                    if (!err) begin
                        err      <= 1'b1;
                        fail_rs1 <= stage_rs1;
                        fail_rs2 <= stage_rs2;
                        fail_rd  <= stage_rd;
                    end
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        num_lat     <= num_vec;
                        accepted    <= '0;
                        pass_cnt    <= '0;
                        fail_cnt    <= '0;
                        err         <= 1'b0;
                        fail_rs1    <= '0;
                        fail_rs2    <= '0;
                        fail_rd     <= '0;
                        stage_valid <= 1'b0;
                        if (num_vec != '0) begin
                            state      <= ST_RUN;
                            busy       <= 1'b1;
                            in_ready_q <= 1'b1;
                            done       <= 1'b0;
                        end else begin
                            // Empty run: nothing to score, report completion at once.
                            state      <= ST_DONE;
                            busy       <= 1'b0;
                            in_ready_q <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (handshake) begin
                        stage_valid <= 1'b1;
                        stage_rs1   <= in_if.in_rs1;
                        stage_rs2   <= in_if.in_rs2;
                        stage_rd    <= in_if.in_rd;
                        stage_uns   <= in_if.in_unsigned;
                        accepted    <= accepted + CNT_W'(1);
                        if ((accepted + CNT_W'(1)) == num_lat) begin
                            state      <= ST_DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end

                ST_DRAIN: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end

                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_slt_checker.sv
// Scoreboard bench for the SLT response checker.
module tb_alu_slt_checker;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rd;
        logic        uns;
    } vec_t;

    typedef struct {
        vec_t v;
        bit   exp_pass;
        int   due;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vec = '0;
    logic        busy, done, err;
    logic [15:0] pass_cnt, fail_cnt;
    logic [31:0] fail_rs1, fail_rs2, fail_rd;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_hs_cyc = 0;
    int   exp_pass = 0;
    int   exp_fail = 0;
    bit   exp_err = 1'b0;
    vec_t exp_fv;

    vec_t stim_q[$];
    bit   valid_pat[$];
    sb_t  sb_q[$];

    alu_slt_checker_if #(.XLEN(32)) bus ();

    alu_slt_checker #(.XLEN(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_vec  (num_vec),
        .in_if    (bus),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .err      (err),
        .fail_rs1 (fail_rs1),
        .fail_rs2 (fail_rs2),
        .fail_rd  (fail_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [31:0] rd, logic u);
        vec_t v;
        v.rs1 = a;
        v.rs2 = b;
        v.rd  = rd;
        v.uns = u;
        return v;
    endfunction

    function automatic bit ref_pass(vec_t v);
        logic lt;
        if (v.uns) lt = (v.rs1 < v.rs2);
        else       lt = ($signed(v.rs1) < $signed(v.rs2));
        return (v.rd === {31'b0, lt});
    endfunction

    task automatic do_start(input int n);
        @(negedge clk);
        start   = 1'b1;
        num_vec = 16'(n);
        @(negedge clk);
        start    = 1'b0;
        exp_pass = 0;
        exp_fail = 0;
        exp_err  = 1'b0;
        exp_fv   = mk(32'd0, 32'd0, 32'd0, 1'b0);
        sb_q.delete();
    endtask

    // Drives stim_q under valid_pat and scores each accepted vector as it retires.
    task automatic run_stream(input int max_cycles);
        int  n;
        bit  v;
        sb_t s;
        n = 0;
        while ((stim_q.size() != 0 || sb_q.size() != 0) && n < max_cycles) begin
            @(negedge clk);
            n++;
            while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                s = sb_q.pop_front();
                if (s.exp_pass) begin
                    if (exp_pass != 65535) exp_pass++;
                end else begin
                    if (exp_fail != 65535) exp_fail++;
                    if (!exp_err) begin
                        exp_err = 1'b1;
                        exp_fv  = s.v;
                    end
                end
                checks++;
                if (pass_cnt !== 16'(exp_pass) || fail_cnt !== 16'(exp_fail)) begin
                    errors++;
                    $display("FAIL sb_counts: pass_cnt=%0d fail_cnt=%0d required pass_cnt=%0d fail_cnt=%0d",
                             pass_cnt, fail_cnt, exp_pass, exp_fail);
                end
                checks++;
                if (err !== exp_err || fail_rs1 !== exp_fv.rs1 || fail_rs2 !== exp_fv.rs2 ||
                    fail_rd !== exp_fv.rd) begin
                    errors++;
                    $display("FAIL sb_capture: err=%b rs1=%h rs2=%h rd=%h required err=%b rs1=%h rs2=%h rd=%h",
                             err, fail_rs1, fail_rs2, fail_rd, exp_err, exp_fv.rs1, exp_fv.rs2, exp_fv.rd);
                end
            end
            if (stim_q.size() == 0 && sb_q.size() != 0) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_early: done=%b required 0 while scoring pending", done);
                end
            end
            if (stim_q.size() != 0) begin
                v = (valid_pat.size() != 0) ? valid_pat.pop_front() : 1'b1;
                if (v) begin
                    bus.in_rs1      = stim_q[0].rs1;
                    bus.in_rs2      = stim_q[0].rs2;
                    bus.in_rd       = stim_q[0].rd;
                    bus.in_unsigned = stim_q[0].uns;
                    bus.in_valid    = 1'b1;
                    if (bus.in_ready === 1'b1) begin
                        s.v        = stim_q.pop_front();
                        s.exp_pass = ref_pass(s.v);
                        s.due      = cyc + 2;
                        sb_q.push_back(s);
                        last_hs_cyc = cyc;
                    end
                end else begin
                    bus.in_valid = 1'b0;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        if (stim_q.size() != 0 || sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: %0d vectors unsent, %0d unscored after %0d cycles, required 0",
                     stim_q.size(), sb_q.size(), n);
            stim_q.delete();
            sb_q.delete();
        end
        valid_pat.delete();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, busy, done, err} !== 4'b0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 ||
            fail_rs1 !== 32'd0 || fail_rs2 !== 32'd0 || fail_rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: rdy/busy/done/err=%b%b%b%b pass=%0d fail=%0d required all zero",
                     bus.in_ready, busy, done, err, pass_cnt, fail_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_signed();
        do_start(5);
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL run_start: busy=%b in_ready=%b done=%b required 1 1 0", busy, bus.in_ready, done);
        end
        stim_q.push_back(mk(32'd2, 32'd1, 32'd0, 1'b0));
        stim_q.push_back(mk(32'd1, 32'd2, 32'd1, 1'b0));
        stim_q.push_back(mk(32'd1, 32'd1, 32'd0, 1'b0));
        stim_q.push_back(mk(32'hFFFFFFFF, 32'd1, 32'd1, 1'b0));
        stim_q.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 1'b0));
        run_stream(40);
        checks++;
        if (pass_cnt !== 16'd5 || fail_cnt !== 16'd0 || err !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL signed_run: pass=%0d fail=%0d err=%b done=%b busy=%b required 5 0 0 1 0",
                     pass_cnt, fail_cnt, err, done, busy);
        end
    endtask

    task automatic test_fail_capture();
        do_start(5);
        stim_q.push_back(mk(32'd2, 32'd1, 32'd1, 1'b0));
        stim_q.push_back(mk(32'd1, 32'd2, 32'd1, 1'b0));
        stim_q.push_back(mk(32'd1, 32'd1, 32'd0, 1'b0));
        stim_q.push_back(mk(32'hFFFFFFFF, 32'd1, 32'd1, 1'b0));
        stim_q.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 1'b0));
        run_stream(40);
        checks++;
        if (pass_cnt !== 16'd4 || fail_cnt !== 16'd1 || err !== 1'b1 || fail_rs1 !== 32'd2 ||
            fail_rs2 !== 32'd1 || fail_rd !== 32'd1) begin
            errors++;
            $display("FAIL one_fail: pass=%0d fail=%0d err=%b rs1=%h rs2=%h rd=%h required 4 1 1 2 1 1",
                     pass_cnt, fail_cnt, err, fail_rs1, fail_rs2, fail_rd);
        end
        do_start(3);
        stim_q.push_back(mk(32'd2, 32'd1, 32'd1, 1'b0));
        stim_q.push_back(mk(32'd1, 32'd2, 32'd1, 1'b0));
        stim_q.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0));
        run_stream(40);
        checks++;
        if (fail_cnt !== 16'd2 || pass_cnt !== 16'd1 || fail_rs1 !== 32'd2 || fail_rs2 !== 32'd1 ||
            fail_rd !== 32'd1) begin
            errors++;
            $display("FAIL first_fail_frozen: fail=%0d pass=%0d rs1=%h rs2=%h rd=%h required 2 1 2 1 1",
                     fail_cnt, pass_cnt, fail_rs1, fail_rs2, fail_rd);
        end
    endtask

    task automatic test_upper_bits();
        do_start(3);
        stim_q.push_back(mk(32'hFFFFFFFF, 32'd1, 32'd0, 1'b1));
        stim_q.push_back(mk(32'hFFFFFFFF, 32'd1, 32'd1, 1'b0));
        stim_q.push_back(mk(32'hFFFFFFFF, 32'd1, 32'd3, 1'b0));
        run_stream(30);
        checks++;
        if (pass_cnt !== 16'd2 || fail_cnt !== 16'd1 || fail_rd !== 32'd3 || fail_rs1 !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL upper_bits: pass=%0d fail=%0d rd=%h rs1=%h required 2 1 00000003 ffffffff",
                     pass_cnt, fail_cnt, fail_rd, fail_rs1);
        end
    endtask

    task automatic test_valid_gaps();
        do_start(4);
        valid_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        stim_q.push_back(mk(32'd5, 32'd7, 32'd1, 1'b0));
        stim_q.push_back(mk(32'h80000000, 32'd0, 32'd1, 1'b0));
        stim_q.push_back(mk(32'h80000000, 32'd0, 32'd0, 1'b1));
        stim_q.push_back(mk(32'd7, 32'd7, 32'd0, 1'b1));
        run_stream(40);
        checks++;
        if (done !== 1'b1 || bus.in_ready !== 1'b0 || cyc - last_hs_cyc != 2) begin
            errors++;
            $display("FAIL gaps_done: done=%b in_ready=%b cycles_after_hs=%0d required 1 0 2",
                     done, bus.in_ready, cyc - last_hs_cyc);
        end
        bus.in_rs1 = 32'd1; bus.in_rs2 = 32'd2; bus.in_rd = 32'd1; bus.in_unsigned = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL extra_ready: in_ready=%b required 0 after run", bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0) begin
            errors++;
            $display("FAIL gaps_counts: pass=%0d fail=%0d required 4 0", pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        do_start(0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_run: done=%b busy=%b pass=%0d fail=%0d rdy=%b required 1 0 0 0 0",
                     done, busy, pass_cnt, fail_cnt, bus.in_ready);
        end
        do_start(3);
        stim_q.push_back(mk(32'd3, 32'd9, 32'd1, 1'b1));
        run_stream(20);
        @(negedge clk);
        start = 1'b1; num_vec = 16'd7;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || pass_cnt !== 16'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run: busy=%b pass=%0d done=%b required 1 1 0", busy, pass_cnt, done);
        end
        stim_q.push_back(mk(32'd9, 32'd3, 32'd0, 1'b1));
        stim_q.push_back(mk(32'd0, 32'd0, 32'd0, 1'b0));
        run_stream(30);
        checks++;
        if (pass_cnt !== 16'd3 || done !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_run: pass=%0d done=%b rdy=%b required 3 1 0", pass_cnt, done, bus.in_ready);
        end
    endtask

    task automatic test_random();
        vec_t v;
        do_start(8);
        for (int i = 0; i < 8; i++) begin
            v.rs1 = $urandom();
            v.rs2 = (i % 3 == 0) ? v.rs1 : $urandom();
            v.uns = 1'($urandom_range(0, 1));
            v.rd  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1));
            stim_q.push_back(v);
            valid_pat.push_back(1'($urandom_range(0, 1)));
            valid_pat.push_back(1'b1);
        end
        run_stream(80);
        checks++;
        if (done !== 1'b1 || 32'(pass_cnt) + 32'(fail_cnt) != 8) begin
            errors++;
            $display("FAIL random_total: done=%b pass+fail=%0d required 1 8", done, pass_cnt + fail_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(4);
        stim_q.push_back(mk(32'd1, 32'd2, 32'd0, 1'b0));
        stim_q.push_back(mk(32'd2, 32'd1, 32'd0, 1'b0));
        run_stream(20);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, busy, done, err} !== 4'b0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 ||
            fail_rs1 !== 32'd0 || fail_rs2 !== 32'd0 || fail_rd !== 32'd0) begin
            errors++;
            $display("FAIL mid_run_reset: rdy/busy/done/err=%b%b%b%b pass=%0d fail=%0d rs1=%h required all zero",
                     bus.in_ready, busy, done, err, pass_cnt, fail_cnt, fail_rs1);
        end
        @(negedge clk);
        rst = 1'b0;
        do_start(2);
        stim_q.push_back(mk(32'd4, 32'd8, 32'd1, 1'b1));
        stim_q.push_back(mk(32'hFFFFFFF0, 32'd8, 32'd1, 1'b0));
        run_stream(20);
        checks++;
        if (pass_cnt !== 16'd2 || fail_cnt !== 16'd0 || err !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_run: pass=%0d fail=%0d err=%b done=%b required 2 0 0 1",
                     pass_cnt, fail_cnt, err, done);
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_rs1      = '0;
        bus.in_rs2      = '0;
        bus.in_rd       = '0;
        bus.in_unsigned = 1'b0;
        exp_fv          = mk(32'd0, 32'd0, 32'd0, 1'b0);
        test_reset();
        test_signed();
        test_fail_capture();
        test_upper_bits();
        test_valid_gaps();
        test_zero_and_ignored_start();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
